// File: rtl/ringbuf.sv
// rtl/ringbuf.sv - 24-bit sample ring buffer with offset read from the oldest entry
//
// FIR history window for the single-channel resampler. Samples enter with a
// one-cycle write strobe; the oldest is retired with a one-cycle pop strobe.
// Taps are read combinationally at (rptr + offset_i) mod LEN, so a tap is
// available in the same cycle as its coefficient ROM word.
//
// Ports:
//   clk       - single clock, rising-edge state updates
//   rst       - synchronous active-low reset
//   data_i    - sample to write
//   we_i      - write strobe, one sample per high cycle
//   pop_i     - retire oldest sample, one per high cycle
//   offset_i  - tap index relative to the oldest sample
//   data_o    - entry at (rptr + offset_i) mod LEN
//   count_o   - number of stored samples, 0..LEN
//   empty_o   - count_o == 0
//   full_o    - count_o == LEN
module ringbuf #(
  parameter int LEN      = 64,
  parameter int LEN_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [23:0]         data_i,
  input  logic                we_i,
  input  logic                pop_i,
  input  logic [LEN_LOG2-1:0] offset_i,
  output logic [23:0]         data_o,
  output logic [LEN_LOG2:0]   count_o,
  output logic                empty_o,
  output logic                full_o
);

  localparam logic [LEN_LOG2:0]   CNT_ONE = (LEN_LOG2+1)'(1);
  localparam logic [LEN_LOG2:0]   CNT_LEN = (LEN_LOG2+1)'(LEN);
  localparam logic [LEN_LOG2-1:0] PTR_ONE = LEN_LOG2'(1);

  logic [23:0]         mem_q [LEN];
  logic [LEN_LOG2-1:0] wptr_q, wptr_d;
  logic [LEN_LOG2-1:0] rptr_q, rptr_d;
  logic [LEN_LOG2:0]   count_q, count_d;
  logic [LEN_LOG2-1:0] rd_idx;
  logic                is_empty, is_full;
  logic                pop_acc, wr_acc;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_LEN);

  // A pop is judged on the pre-edge count only, so a pop while empty stays
  // ignored even when a write lands in the same cycle. A write while full is
  // only allowed when the same-cycle pop frees a slot.
  assign pop_acc = pop_i && !is_empty;
  assign wr_acc  = we_i && (!is_full || pop_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop_acc) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (wr_acc && !pop_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so that untouched taps read back as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Truncating add gives the mod-LEN wrap for free.
  assign rd_idx  = rptr_q + offset_i;
  assign data_o  = mem_q[rd_idx];
  assign count_o = count_q;
  assign empty_o = is_empty;
  assign full_o  = is_full;

endmodule

// File: tb/tb_ringbuf.sv
// tb/tb_ringbuf.sv - directed self-checking bench for ringbuf
module tb_ringbuf;

  logic        clk;
  logic        rst;
  logic [23:0] data_i;
  logic        we_i;
  logic        pop_i;
  logic [5:0]  offset_i;
  logic [23:0] data_o;
  logic [6:0]  count_o;
  logic        empty_o;
  logic        full_o;

  int total;
  int bad;

  ringbuf #(.LEN(64), .LEN_LOG2(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .we_i     (we_i),
    .pop_i    (pop_i),
    .offset_i (offset_i),
    .data_o   (data_o),
    .count_o  (count_o),
    .empty_o  (empty_o),
    .full_o   (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tap(input string tag, input int off, input logic [23:0] exp);
    offset_i = 6'(off);
    #1;
    check(tag, {8'h0, data_o}, {8'h0, exp});
  endtask

  task automatic flags(input string tag, input int cnt, input logic emp, input logic ful);
    check({tag, "_count"}, {25'h0, count_o}, 32'(cnt));
    check({tag, "_empty"}, {31'h0, empty_o}, {31'h0, emp});
    check({tag, "_full"},  {31'h0, full_o},  {31'h0, ful});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    data_i   = '0;
    we_i     = 1'b0;
    pop_i    = 1'b0;
    offset_i = '0;

    // Reset held two cycles
    cycle();
    cycle();
    flags("reset", 0, 1'b1, 1'b0);
    tap("reset_off0", 0, 24'h0);
    tap("reset_off5", 5, 24'h0);
    tap("reset_off63", 63, 24'h0);
    rst = 1'b1;

    // Fill five samples
    for (int i = 1; i <= 5; i++) begin
      data_i = 24'(i);
      we_i   = 1'b1;
      cycle();
    end
    we_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tap("fill_tap", k, 24'(k + 1));
    end
    flags("fill", 5, 1'b0, 1'b0);

    // Single pop
    pop_i = 1'b1;
    cycle();
    pop_i = 1'b0;
    tap("pop_off0", 0, 24'h000002);
    tap("pop_off3", 3, 24'h000005);
    flags("pop", 4, 1'b0, 1'b0);

    // Four pops empty the buffer, fifth is ignored; rptr must rest at 5
    pop_i = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    pop_i = 1'b0;
    flags("drain", 0, 1'b1, 1'b0);
    tap("drain_off63", 63, 24'h000005);
    tap("drain_off60", 60, 24'h000002);

    // 65 writes: 64 fill, the last is dropped
    for (int i = 0; i <= 64; i++) begin
      data_i = 24'h100000 + 24'(i);
      we_i   = 1'b1;
      cycle();
    end
    we_i = 1'b0;
    flags("full", 64, 1'b0, 1'b1);
    tap("full_off0", 0, 24'h100000);
    tap("full_off63", 63, 24'h10003F);

    // Simultaneous write and pop while full
    data_i = 24'hABCDEF;
    we_i   = 1'b1;
    pop_i  = 1'b1;
    cycle();
    we_i  = 1'b0;
    pop_i = 1'b0;
    flags("fullwp", 64, 1'b0, 1'b1);
    tap("fullwp_off0", 0, 24'h100001);
    tap("fullwp_off63", 63, 24'hABCDEF);

    // Clean restart, then write+pop while empty: only the write applies
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    flags("rst2", 0, 1'b1, 1'b0);
    data_i = 24'h777777;
    we_i   = 1'b1;
    pop_i  = 1'b1;
    cycle();
    we_i  = 1'b0;
    pop_i = 1'b0;
    flags("emptywp", 1, 1'b0, 1'b0);
    tap("emptywp_off0", 0, 24'h777777);
    pop_i = 1'b1;
    cycle();
    pop_i = 1'b0;
    flags("emptywp_pop", 0, 1'b1, 1'b0);

    // Streaming with wrap: 200 samples, pop every cycle after the first 32
    for (int j = 0; j < 200; j++) begin
      data_i = 24'h200000 + 24'(j);
      we_i   = 1'b1;
      pop_i  = (j >= 32);
      cycle();
      if (j == 31 || j == 50 || j == 130 || j == 199) begin
        check("stream_count", {25'h0, count_o}, 32'd32);
        tap("stream_off0",  0,  24'h200000 + 24'(j - 31));
        tap("stream_off17", 17, 24'h200000 + 24'(j - 14));
        tap("stream_off31", 31, 24'h200000 + 24'(j));
      end
    end

    // Reset with strobes still active: reset wins
    rst = 1'b0;
    cycle();
    we_i  = 1'b0;
    pop_i = 1'b0;
    rst   = 1'b1;
    flags("midrst", 0, 1'b1, 1'b0);
    tap("midrst_off0", 0, 24'h0);
    tap("midrst_off31", 31, 24'h0);
    tap("midrst_off63", 63, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ringbuf.md
# ringbuf

24-bit sample ring buffer with random-access read relative to the oldest sample, used as the FIR history window of the single-channel resampler. The upstream source writes samples with a one-cycle strobe. The resampler reads a window of taps via `offset_i` and retires the oldest sample with `pop_i`. Read is combinational so a tap and its coefficient ROM word are available in the same cycle.

## Interface
Parameters:
- `LEN`, default 64: number of 24-bit entries; must be a power of two.
- `LEN_LOG2`, default 6: log2(`LEN`); width of pointers and `offset_i`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous and active-low (reset when `rst`=0 at a rising edge).
- `data_i`  in  24: sample to write.
- `we_i`  in  1: write strobe; one sample per high cycle.
- `pop_i`  in  1: retire oldest sample; one per high cycle.
- `offset_i`  in  `LEN_LOG2`: tap index relative to the oldest sample.
- `data_o`  out  24: entry at (read pointer + `offset_i`) mod `LEN`.
- `count_o`  out  `LEN_LOG2`+1: number of stored samples, 0..`LEN`.
- `empty_o`  out  1: `count_o`==0.
- `full_o`  out  1: `count_o`==`LEN`.

## Operation
- State:
  - `LEN`×24 storage array.
  - Write pointer `wptr` and read pointer `rptr`, each `LEN_LOG2` bits, wrapping mod `LEN`.
  - Counter `count`.
- Reset (`rst`=0 at a clock edge):
  - `wptr`=0, `rptr`=0, `count`=0.
  - All storage entries cleared to 0.
  - Resulting outputs: `data_o`=0 for any offset, `empty_o`=1, `full_o`=0, `count_o`=0.
  - Reset wins over any simultaneous `we_i`/`pop_i`.
- Write:
  - Applies when `we_i`=1 and (not full, or `pop_i` accepted in the same cycle).
  - Stores `data_i` at `wptr`, then `wptr`+1.
  - A write while full without an accepted pop is dropped; no state changes.
- Pop:
  - Applies when `pop_i`=1 and `count`>0: `rptr`+1.
  - A pop while empty is ignored, even if `we_i`=1 in the same cycle.
- Count update:
  - +1 on an accepted write only.
  - −1 on an accepted pop only.
  - Unchanged when both or neither are accepted.
- Read:
  - `data_o` = mem[(`rptr` + `offset_i`) mod `LEN`], purely combinational from the registered pointers, the memory and `offset_i`.
  - Offsets ≥ `count` return stale contents (0 if never written since reset). No error is flagged; the caller is responsible.
- Pointer arithmetic truncates to `LEN_LOG2` bits, giving natural wrap-around.
- Data is stored and returned unmodified; no sign handling.

## Timing
- Written sample readable on `data_o` the cycle after the `we_i` edge.
- `offset_i` → `data_o`: zero cycles (combinational).
- Pop takes effect at the edge. From the next cycle, offset 0 returns the previously second-oldest sample.
- `count_o`, `empty_o`, `full_o` are registered-derived; they update the cycle after the causing edge.
- Simultaneous write and pop in one cycle:
  - Both apply.
  - The read window reflects the advanced `rptr` and the new sample from the next cycle.
- `rst` low for one edge fully reinitialises the block, regardless of its state at the time.

## Test plan
- Reset: drive `rst`=0 for 2 cycles → `count_o`=0, `empty_o`=1, `full_o`=0, `data_o`=0 for offsets 0, 5 and 63.
- Fill and tap:
  - Write 0x000001..0x000005 on consecutive cycles.
  - Sweep `offset_i` 0..4 → `data_o` 0x000001..0x000005; `count_o`=5.
- Pop:
  - After the above, pulse `pop_i` once.
  - Offset 0 → 0x000002, offset 3 → 0x000005; `count_o`=4.
  - 5 further pops (last one while empty) → `count_o`=0, `empty_o`=1, `rptr` unchanged by the extra pop.
- Full/overflow:
  - Write 0x100000+i for i=0..64 (65 writes) → `full_o`=1, `count_o`=64.
  - Offset 63 → 0x10003F; the 65th sample is dropped.
- Simultaneous while full:
  - `we_i`=1, `pop_i`=1 with 0xABCDEF → `count_o` stays 64.
  - Offset 0 → 0x100001, offset 63 → 0xABCDEF.
- Wrap-around:
  - Stream 200 samples with a pop every cycle after the first 32.
  - Offset k equals the sample written 32−k cycles earlier (mod-64 wrap verified).
  - Mid-stream `rst`=0 → all state cleared, `data_o`=0.
